invader_controller: RTL and testbench

Sequences the invader formation that feeds formatVGA, replacing the constant invArray/invLine ties in the top level.
- Marches the 20-slot formation left and right on a timed step.
- Drops the formation one line at each edge.
- Detects bullet hits and clears the hit invader.
- Raises a one-cycle hit pulse toward the player block.
- Flags win or lose.

---
 rtl/si_pkg.sv | 9 +
 rtl/invader_controller_if.sv | 25 ++
 rtl/inv_step_timer.sv | 49 ++++
 rtl/invader_controller.sv | 107 ++++++++++
 tb/tb_invader_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/si_pkg.sv
// Shared types and constants for the invader formation sequencer.
package si_pkg;
    localparam int COLS = 20;
    localparam int LINE_W = 5;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT = 1'b1;

    typedef enum logic [1:0] {IDLE, MARCH, WIN, LOSE} state_t;
endpackage

// File: rtl/invader_controller_if.sv
// Game-side bus of the invader controller: run controls and bullet in, formation and flags out.
interface invader_controller_if;
    import si_pkg::*;

    logic              enable;
    logic              start;
    logic [4:0]        bulletCol;
    logic [LINE_W-1:0] bulletRow;
    logic              bulletFlying;
    logic [COLS-1:0]   invArray;
    logic [LINE_W-1:0] invLine;
    logic              hit;
    logic              win;
    logic              lose;
    logic              dir;

    modport master (
        output enable, start, bulletCol, bulletRow, bulletFlying,
        input  invArray, invLine, hit, win, lose, dir
    );
    modport slave (
        input  enable, start, bulletCol, bulletRow, bulletFlying,
        output invArray, invLine, hit, win, lose, dir
    );
endinterface

// File: rtl/inv_step_timer.sv
// March step timer: counts enabled cycles and pulses step at the end of each period.
// INV_SPEEDUP_EN: shorten the period as the alive count of the formation drops.
module inv_step_timer
    import si_pkg::*;
#(
    parameter int STEP_TICKS = 6000000
) (
    input  logic            dclk,
    input  logic            clr,
    input  logic            run,
    input  logic            clear,
    input  logic [COLS-1:0] alive,
    output logic            step
);
    localparam int CW = $clog2(STEP_TICKS);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

`ifdef INV_SPEEDUP_EN
    localparam int AW = $clog2(COLS + 1);
    logic [AW-1:0] n_alive;

    always_comb begin
        n_alive = '0;
        for (int i = 0; i < COLS; i++)
            n_alive = n_alive + AW'(alive[i]);
    end

    always_comb begin
        if (n_alive >= AW'(8))      last = CW'(STEP_TICKS - 1);
        else if (n_alive >= AW'(4)) last = CW'((STEP_TICKS >> 1) - 1);
        else if (n_alive >= AW'(2)) last = CW'((STEP_TICKS >> 2) - 1);
        else                        last = CW'((STEP_TICKS >> 3) - 1);
    end
`else
    logic unused_alive;
    assign unused_alive = ^alive;
    assign last = CW'(STEP_TICKS - 1);
`endif

    // >= so a count left over from a longer period steps at once
    assign step = run && (cnt >= last);

    always_ff @(posedge dclk) begin
        if (!clr || clear) cnt <= '0;
        else if (run)      cnt <= step ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/invader_controller.sv
// Invader formation sequencer: march/drop timing, bullet hits, win/lose detection.
// Optional INV_SPEEDUP_EN (in inv_step_timer) speeds the march as invaders die.
module invader_controller
    import si_pkg::*;
#(
    parameter int              STEP_TICKS  = 6000000,
    parameter logic [COLS-1:0] START_ARRAY = 20'b00101010101010101010,
    parameter int              START_LINE  = 4,
    parameter int              LOSE_LINE   = 28
) (
    input  logic                 dclk,
    input  logic                 clr,
    invader_controller_if.slave  bus
);
    state_t            state, state_nx;
    logic [COLS-1:0]   arr, arr_nx, arr_hit, kill;
    logic [LINE_W-1:0] line, line_nx;
    logic              dir_q, dir_nx;
    logic              hit_q, hit_nx;
    logic              lock, lock_nx;
    logic              marching, step, hit_take, edge_bit;
    logic [31:0]       arr_ext;

    assign marching = (state == MARCH);
    assign arr_ext  = 32'(arr);
    assign hit_take = bus.enable && marching && !lock && bus.bulletFlying &&
                      (bus.bulletRow == line) && (int'(bus.bulletCol) < COLS) &&
                      arr_ext[bus.bulletCol];
    assign kill     = COLS'(1) << bus.bulletCol;
    // a kill lands before this edge's shift/drop decision
    assign arr_hit  = hit_take ? (arr & ~kill) : arr;
    assign edge_bit = (dir_q == DIR_RIGHT) ? arr_hit[COLS-1] : arr_hit[0];

    inv_step_timer #(.STEP_TICKS(STEP_TICKS)) u_timer (
        .dclk  (dclk),
        .clr   (clr),
        .run   (bus.enable && marching),
        .clear (bus.enable && !marching),
        .alive (arr),
        .step  (step)
    );

    always_comb begin
        state_nx = state;
        arr_nx   = arr;
        line_nx  = line;
        dir_nx   = dir_q;
        hit_nx   = 1'b0;
        lock_nx  = lock;
        if (bus.enable) begin
            hit_nx = hit_take;
            if (hit_take)               lock_nx = 1'b1;
            else if (!bus.bulletFlying) lock_nx = 1'b0;
            case (state)
                MARCH: begin
                    arr_nx = arr_hit;
                    if (arr == '0) begin
                        state_nx = WIN;
                    end else if (step) begin
                        if (edge_bit) begin
                            line_nx = line + LINE_W'(1);
                            dir_nx  = ~dir_q;
                            if (int'(line) + 1 >= LOSE_LINE) state_nx = LOSE;
                        end else if (dir_q == DIR_RIGHT) begin
                            arr_nx = arr_hit << 1;
                        end else begin
                            arr_nx = arr_hit >> 1;
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        arr_nx   = START_ARRAY;
                        line_nx  = LINE_W'(START_LINE);
                        dir_nx   = DIR_RIGHT;
                        state_nx = (START_LINE >= LOSE_LINE) ? LOSE : MARCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge dclk) begin
        if (!clr) begin
            state <= IDLE;
            arr   <= START_ARRAY;
            line  <= LINE_W'(START_LINE);
            dir_q <= DIR_RIGHT;
            hit_q <= 1'b0;
            lock  <= 1'b0;
        end else begin
            state <= state_nx;
            arr   <= arr_nx;
            line  <= line_nx;
            dir_q <= dir_nx;
            hit_q <= hit_nx;
            lock  <= lock_nx;
        end
    end

    assign bus.invArray = arr;
    assign bus.invLine  = line;
    assign bus.dir      = dir_q;
    assign bus.hit      = hit_q && bus.enable;
    assign bus.win      = (state == WIN);
    assign bus.lose     = (state == LOSE);
endmodule

// File: tb/tb_invader_controller.sv
module tb_invader_controller;
    import si_pkg::*;

    logic dclk = 1'b0;
    logic clr  = 1'b0;
    always #5 dclk = ~dclk;

    invader_controller_if b0 ();
    invader_controller_if b1 ();
    invader_controller_if b2 ();
    invader_controller_if b3 ();

    invader_controller #(.STEP_TICKS(8)) u0 (.dclk(dclk), .clr(clr), .bus(b0));
    invader_controller #(.STEP_TICKS(8), .START_ARRAY(20'b1)) u1 (.dclk(dclk), .clr(clr), .bus(b1));
    invader_controller #(.STEP_TICKS(8), .START_ARRAY(20'h80000), .LOSE_LINE(5))
        u2 (.dclk(dclk), .clr(clr), .bus(b2));
    invader_controller #(.STEP_TICKS(16), .START_ARRAY(20'b111)) u3 (.dclk(dclk), .clr(clr), .bus(b3));

    logic [28:0] obs [4];
    assign obs[0] = {b0.invArray, b0.invLine, b0.dir, b0.hit, b0.win, b0.lose};
    assign obs[1] = {b1.invArray, b1.invLine, b1.dir, b1.hit, b1.win, b1.lose};
    assign obs[2] = {b2.invArray, b2.invLine, b2.dir, b2.hit, b2.win, b2.lose};
    assign obs[3] = {b3.invArray, b3.invLine, b3.dir, b3.hit, b3.win, b3.lose};

    typedef struct {
        int          cyc;
        int          inst;
        int          id;
        logic [28:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_id   = 0;

    always @(posedge dclk) cyc <= cyc + 1;

    function automatic logic [28:0] pk(logic [19:0] m, int l, logic d, logic h, logic w, logic lo);
        return {m, 5'(l), d, h, w, lo};
    endfunction

    task automatic expect_at(int inst, int k, logic [28:0] v);
        exp_t e;
        int   i;
        e.cyc  = cyc + k;
        e.inst = inst;
        e.id   = n_id;
        e.v    = v;
        n_id++;
        i = q.size();
        while (i > 0 && q[i-1].cyc > e.cyc) i--;
        q.insert(i, e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    always @(negedge dclk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc || obs[e.inst] !== e.v) begin
                n_fail++;
                $display("FAIL check_%0d inst%0d cyc %0d: got {mask,line,dir,hit,win,lose}=%h, want %h",
                         e.id, e.inst, e.cyc, obs[e.inst], e.v);
            end
        end
    end

    initial begin
        exp_t e;
        b0.enable = 1'b1; b0.start = 1'b0; b0.bulletCol = '0; b0.bulletRow = '0; b0.bulletFlying = 1'b0;
        b1.enable = 1'b1; b1.start = 1'b0; b1.bulletCol = '0; b1.bulletRow = '0; b1.bulletFlying = 1'b0;
        b2.enable = 1'b1; b2.start = 1'b0; b2.bulletCol = '0; b2.bulletRow = '0; b2.bulletFlying = 1'b0;
        b3.enable = 1'b1; b3.start = 1'b0; b3.bulletCol = '0; b3.bulletRow = '0; b3.bulletFlying = 1'b0;

        tick(2);
        expect_at(0, 0, pk(20'b00101010101010101010, 4, 0, 0, 0, 0));
        expect_at(1, 0, pk(20'b1, 4, 0, 0, 0, 0));
        expect_at(2, 0, pk(20'h80000, 4, 0, 0, 0, 0));
        expect_at(3, 0, pk(20'b111, 4, 0, 0, 0, 0));
        clr = 1'b1;
        tick(1);

        b0.start = 1'b1; tick(1); b0.start = 1'b0;
        expect_at(0, 7,  pk(20'b00101010101010101010, 4, 0, 0, 0, 0));
        expect_at(0, 8,  pk(20'b01010101010101010100, 4, 0, 0, 0, 0));
        expect_at(0, 16, pk(20'b10101010101010101000, 4, 0, 0, 0, 0));
        expect_at(0, 23, pk(20'b10101010101010101000, 4, 0, 0, 0, 0));
        expect_at(0, 24, pk(20'b10101010101010101000, 5, 1, 0, 0, 0));
        tick(25);

        clr = 1'b0; tick(1); clr = 1'b1;
        expect_at(0, 0,  pk(20'b00101010101010101010, 4, 0, 0, 0, 0));
        expect_at(0, 10, pk(20'b00101010101010101010, 4, 0, 0, 0, 0));
        tick(10);

        b0.start = 1'b1; tick(1); b0.start = 1'b0;
        b0.bulletCol = 5'd1; b0.bulletRow = 5'd4; b0.bulletFlying = 1'b1;
        expect_at(0, 1, pk(20'b00101010101010101000, 4, 0, 1, 0, 0));
        expect_at(0, 2, pk(20'b00101010101010101000, 4, 0, 0, 0, 0));
        expect_at(0, 5, pk(20'b00101010101010101000, 4, 0, 0, 0, 0));
        tick(5);
        b0.bulletFlying = 1'b0; tick(1);
        b0.bulletCol = 5'd3; b0.bulletFlying = 1'b1;
        expect_at(0, 1, pk(20'b00101010101010100000, 4, 0, 1, 0, 0));
        expect_at(0, 2, pk(20'b01010101010101000000, 4, 0, 0, 0, 0));
        tick(2); b0.bulletFlying = 1'b0;
        tick(7);
        b0.bulletCol = 5'd6; b0.bulletFlying = 1'b1;
        expect_at(0, 1, pk(20'b10101010101000000000, 4, 0, 1, 0, 0));
        tick(1); b0.bulletFlying = 1'b0; tick(1);

        b0.enable = 1'b0; b0.bulletCol = 5'd9; b0.bulletFlying = 1'b1;
        expect_at(0, 10, pk(20'b10101010101000000000, 4, 0, 0, 0, 0));
        expect_at(0, 20, pk(20'b10101010101000000000, 4, 0, 0, 0, 0));
        tick(20);
        b0.enable = 1'b1;
        expect_at(0, 1, pk(20'b10101010100000000000, 4, 0, 1, 0, 0));
        expect_at(0, 6, pk(20'b10101010100000000000, 4, 0, 0, 0, 0));
        expect_at(0, 7, pk(20'b10101010100000000000, 5, 1, 0, 0, 0));
        tick(1); b0.bulletFlying = 1'b0; tick(7);

        b1.start = 1'b1; tick(1); b1.start = 1'b0;
        b1.bulletCol = 5'd0; b1.bulletRow = 5'd5; b1.bulletFlying = 1'b1;
        expect_at(1, 1, pk(20'b1, 4, 0, 0, 0, 0));
        tick(1);
        b1.bulletRow = 5'd4;
        expect_at(1, 1, pk(20'b0, 4, 0, 1, 0, 0));
        expect_at(1, 2, pk(20'b0, 4, 0, 0, 1, 0));
        expect_at(1, 4, pk(20'b0, 4, 0, 0, 1, 0));
        tick(4);
        b1.bulletFlying = 1'b0;
        b1.start = 1'b1; tick(1); b1.start = 1'b0;
        expect_at(1, 0, pk(20'b1, 4, 0, 0, 0, 0));
        expect_at(1, 8, pk(20'b10, 4, 0, 0, 0, 0));
        tick(8);
        n_chk++;
        if (b1.invArray !== 20'b10 || b1.win !== 1'b0) begin
            n_fail++;
            $display("FAIL restart march inst1: mask=%b win=%b", b1.invArray, b1.win);
        end

        b2.start = 1'b1; tick(1); b2.start = 1'b0;
        expect_at(2, 7,  pk(20'h80000, 4, 0, 0, 0, 0));
        expect_at(2, 8,  pk(20'h80000, 5, 1, 0, 0, 1));
        expect_at(2, 20, pk(20'h80000, 5, 1, 0, 0, 1));
        tick(20);
        n_chk++;
        if (b2.lose !== 1'b1 || b2.invLine !== 5'd5 || b2.invArray !== 20'h80000) begin
            n_fail++;
            $display("FAIL lose frozen inst2: lose=%b line=%0d mask=%h", b2.lose, b2.invLine, b2.invArray);
        end
        b2.start = 1'b1; tick(1); b2.start = 1'b0;
        expect_at(2, 0, pk(20'h80000, 4, 0, 0, 0, 0));
        n_chk++;
        if (b2.lose !== 1'b0 || b2.invLine !== 5'd4 || b2.invArray !== 20'h80000) begin
            n_fail++;
            $display("FAIL lose restart inst2: lose=%b line=%0d mask=%h", b2.lose, b2.invLine, b2.invArray);
        end
        tick(1);

        b3.start = 1'b1; tick(1); b3.start = 1'b0;
`ifdef INV_SPEEDUP_EN
        expect_at(3, 3, pk(20'b111, 4, 0, 0, 0, 0));
        expect_at(3, 4, pk(20'b1110, 4, 0, 0, 0, 0));
        tick(4);
        b3.bulletCol = 5'd1; b3.bulletRow = 5'd4; b3.bulletFlying = 1'b1;
        expect_at(3, 1, pk(20'b1100, 4, 0, 1, 0, 0));
        tick(1); b3.bulletFlying = 1'b0; tick(1);
        b3.bulletCol = 5'd2; b3.bulletFlying = 1'b1;
        expect_at(3, 1, pk(20'b1000, 4, 0, 1, 0, 0));
        expect_at(3, 2, pk(20'b10000, 4, 0, 0, 0, 0));
        expect_at(3, 3, pk(20'b10000, 4, 0, 0, 0, 0));
        expect_at(3, 4, pk(20'b100000, 4, 0, 0, 0, 0));
        expect_at(3, 6, pk(20'b1000000, 4, 0, 0, 0, 0));
        tick(7); b3.bulletFlying = 1'b0;
`else
        expect_at(3, 15, pk(20'b111, 4, 0, 0, 0, 0));
        expect_at(3, 16, pk(20'b1110, 4, 0, 0, 0, 0));
        tick(16);
`endif

        tick(2);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL check_%0d inst%0d: expectation for cyc %0d never sampled", e.id, e.inst, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
